lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the execute-stage ALU.
- Consumes the ALU sum (rs1 + imm) as the effective address, together with the store data and funct3.
- Performs one RV32I load or store on a single-outstanding valid/ready memory port.
- Returns aligned, sign/zero-extended load data to writeback.

Parameters:
- None. Data and address widths are fixed at 32; strobe width is fixed at 4.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  LSU can accept an access
- req_addr  in  32  effective byte address (ALU out)
- req_wdata  in  32  store data (rs2)
- req_funct3  in  3  access size/sign, RV32I encoding
- req_store  in  1  1 = store, 0 = load
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  access rejected (qualified by resp_valid)
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accepts the request and returns data this cycle
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables; 0 for loads
- mem_rdata  in  32  load word, valid when mem_valid && mem_ready

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- FSM states: IDLE, BUS, RESP.
- Reset state: IDLE. During and after reset: req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr, wdata, funct3 and store.
  - Legal access -> BUS. Rejected access -> RESP with err=1.
  - mem_ready is ignored in IDLE.
- BUS:
  - req_ready=0 and mem_valid=1.
  - mem_addr, mem_wdata and mem_wstrb come from registers and stay stable until mem_ready.
  - On mem_ready: capture the extended mem_rdata (loads only), then -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Then -> IDLE.
  - No back-to-back accept: the next request is accepted at the earliest in the cycle after RESP.
- Latency: request accepted at edge N; mem_valid high in cycle N+1; with zero-wait mem_ready, resp_valid is high in cycle N+2.
- Loads:
  - funct3 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU.
  - Byte select addr[1:0]; halfword select addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores:
  - funct3 0=SB, 1=SH, 2=SW.
  - SB: wdata {4{b}}, wstrb 4'b0001<<addr[1:0].
  - SH: wdata {2{h}}, wstrb 4'b0011<<{addr[1],1'b0}.
  - SW: wstrb 4'hF.
  - resp_rdata=0.
- Illegal funct3 (load 3/6/7, store 3-7): no bus access; RESP with resp_err=1 and rdata=0. This applies regardless of macro.
- Reset mid-transaction: mem_valid drops asynchronously, the access is abandoned, and no resp_valid is issued.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: halfword with addr[0]=1, or word with addr[1:0]!=0, gets no bus access; RESP follows the cycle after accept with resp_err=1 and rdata=0.
- Undefined:
  - Misaligned low bits are forced to natural alignment: addr[0] is cleared for halfwords, addr[1:0] are cleared for words.
  - The access proceeds normally.
  - resp_err is raised only for illegal funct3.

Decomposition:
- Shared package (common defs): funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW, and an lsu_state_t enum {IDLE, BUS, RESP}.
- Sub-module lsu_align, combinational:
  - Inputs: funct3, addr[1:0], wdata, rdata.
  - Outputs: lane-replicated wdata, wstrb, extended rdata, misaligned flag, illegal flag.
- The top level holds the FSM and the registers.

Test Plan:
- LB, addr 0x1003, mem_rdata 0x80AABBCC, zero-wait -> mem_addr 0x1000, wstrb 0; resp_rdata 0xFFFFFF80 at N+2. LBU same -> 0x00000080.
- SH, addr 0x1002, wdata 0x1234ABCD -> mem_addr 0x1000, mem_wdata 0xABCDABCD, mem_wstrb 0xC; resp_rdata 0, err 0.
- LW, addr 0x2000, mem_ready held low 3 cycles -> mem_valid/addr stable all 4 cycles, req_ready=0; resp_valid 1 cycle after mem_ready, exactly one cycle wide.
- LW, addr 0x1001:
  - with LSU_MISALIGN_TRAP_EN -> mem_valid never asserts; resp_valid and resp_err=1 at N+1.
  - without the macro -> mem_addr 0x1000, normal response.
- Load funct3=3 -> no mem_valid; resp_err=1, rdata 0. Then immediate LW 0x0 -> accepted after RESP and completes normally.
- Assert rst during BUS -> mem_valid=0 immediately, no resp_valid; after release, req_ready=1 and a new SW completes with wstrb 0xF.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU: store replication/strobes, load extension, legality.
// LSU_MISALIGN_TRAP_EN: flag misaligned halfword/word accesses instead of forcing alignment.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_store,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [1:0]  w_size;
  logic [1:0]  w_lo;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_size = i_funct3[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign o_misaligned = ((w_size == 2'd1) && i_addr_lo[0]) ||
                        ((w_size == 2'd2) && (i_addr_lo != 2'b00));
`else
  assign o_misaligned = 1'b0;
`endif

  // Natural alignment is forced here; with the trap enabled such accesses never reach the bus.
  always_comb begin
    w_lo = i_addr_lo;
    if (w_size == 2'd1)      w_lo[0] = 1'b0;
    else if (w_size == 2'd2) w_lo    = 2'b00;
  end

  assign o_illegal = i_store ? (i_funct3 > F3_SW)
                             : !(i_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});

  assign w_byte = i_rdata[{w_lo, 3'b000} +: 8];
  assign w_half = i_rdata[{w_lo[1], 4'b0000} +: 16];

  always_comb begin
    case (i_funct3)
      F3_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_rdata = {24'd0, w_byte};
      F3_LH:   o_rdata = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_rdata = {16'd0, w_half};
      F3_LW:   o_rdata = i_rdata;
      default: o_rdata = 32'd0;
    endcase
  end

  always_comb begin
    case (w_size)
      2'd0:    o_wdata = {4{i_wdata[7:0]}};
      2'd1:    o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

  always_comb begin
    o_wstrb = 4'h0;
    if (i_store && !o_illegal) begin
      case (w_size)
        2'd0:    o_wstrb = 4'b0001 << w_lo;
        2'd1:    o_wstrb = 4'b0011 << {w_lo[1], 1'b0};
        default: o_wstrb = 4'hF;
      endcase
    end
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: single-outstanding valid/ready bus master behind the execute ALU.
// LSU_MISALIGN_TRAP_EN (in lsu_align) turns misaligned halfword/word accesses into errors.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  input  logic        req_store,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  r_state;
  logic [2:0]  r_funct3;
  logic        r_store;
  logic [1:0]  r_addr_lo;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  logic        w_idle;
  logic [2:0]  w_funct3;
  logic        w_store;
  logic [1:0]  w_addr_lo;
  logic [31:0] w_wdata_rep;
  logic [3:0]  w_wstrb;
  logic [31:0] w_rdata_ext;
  logic        w_misaligned;
  logic        w_illegal;
  logic        w_reject;

  // One aligner serves both phases: live request in IDLE, latched request afterwards.
  assign w_idle    = (r_state == IDLE);
  assign w_funct3  = w_idle ? req_funct3    : r_funct3;
  assign w_store   = w_idle ? req_store     : r_store;
  assign w_addr_lo = w_idle ? req_addr[1:0] : r_addr_lo;
  assign w_reject  = w_illegal || w_misaligned;

  lsu_align u_align (
    .i_funct3     (w_funct3),
    .i_store      (w_store),
    .i_addr_lo    (w_addr_lo),
    .i_wdata      (req_wdata),
    .i_rdata      (mem_rdata),
    .o_wdata      (w_wdata_rep),
    .o_wstrb      (w_wstrb),
    .o_rdata      (w_rdata_ext),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_funct3     <= 3'd0;
      r_store      <= 1'b0;
      r_addr_lo    <= 2'b00;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_wstrb  <= 4'h0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_funct3    <= req_funct3;
            r_store     <= req_store;
            r_addr_lo   <= req_addr[1:0];
            r_req_ready <= 1'b0;
            if (w_reject) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else begin
              r_state     <= BUS;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= {req_addr[31:2], 2'b00};
              r_mem_wdata <= w_wdata_rep;
              r_mem_wstrb <= w_wstrb;
            end
          end
        end
        BUS: begin
          if (mem_ready) begin
            r_state      <= RESP;
            r_mem_valid  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_store ? 32'd0 : w_rdata_ext;
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_resp_err  <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_valid  = r_mem_valid;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wstrb  = r_mem_wstrb;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: loads, stores, wait states, errors and mid-access reset.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_store;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .req_store  (req_store),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] f3, input logic st);
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    req_store  = st;
    req_valid  = 1'b1;
  endtask

  // Zero-wait access: accept at edge N, bus in N+1, response in N+2, idle again in N+3.
  task automatic access(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input logic st, input logic [31:0] rd,
                        input logic [31:0] ea, input logic [31:0] ewd, input logic [3:0] ews,
                        input logic [31:0] erd);
    drive_req(a, wd, f3, st);
    mem_rdata = rd;
    mem_ready = 1'b1;
    check({tag, " req_ready before"}, {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    check({tag, " mem_valid"}, {31'd0, mem_valid}, 32'd1);
    check({tag, " mem_addr"}, mem_addr, ea);
    check({tag, " mem_wdata"}, mem_wdata, ewd);
    check({tag, " mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, ews});
    check({tag, " req_ready busy"}, {31'd0, req_ready}, 32'd0);
    check({tag, " resp early"}, {31'd0, resp_valid}, 32'd0);
    step();
    check({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, " resp_rdata"}, resp_rdata, erd);
    check({tag, " resp_err"}, {31'd0, resp_err}, 32'd0);
    check({tag, " mem_valid drop"}, {31'd0, mem_valid}, 32'd0);
    check({tag, " req_ready resp"}, {31'd0, req_ready}, 32'd0);
    step();
    check({tag, " resp one cycle"}, {31'd0, resp_valid}, 32'd0);
    check({tag, " req_ready after"}, {31'd0, req_ready}, 32'd1);
    mem_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_funct3 = 3'd0;
    req_store  = 1'b0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'd0;

    // reset values
    step();
    step();
    check("rst req_ready",  {31'd0, req_ready},  32'd1);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst resp_err",   {31'd0, resp_err},   32'd0);
    check("rst mem_valid",  {31'd0, mem_valid},  32'd0);
    check("rst mem_addr",   mem_addr,  32'd0);
    check("rst mem_wdata",  mem_wdata, 32'd0);
    check("rst mem_wstrb",  {28'd0, mem_wstrb}, 32'd0);
    rst = 1'b0;
    step();
    check("post rst req_ready", {31'd0, req_ready}, 32'd1);
    check("post rst mem_valid", {31'd0, mem_valid}, 32'd0);

    // loads and stores, zero wait
    access("LB",  32'h0000_1003, 32'd0, 3'd0, 1'b0, 32'h80AA_BBCC,
           32'h0000_1000, 32'd0, 4'h0, 32'hFFFF_FF80);
    access("LBU", 32'h0000_1003, 32'd0, 3'd4, 1'b0, 32'h80AA_BBCC,
           32'h0000_1000, 32'd0, 4'h0, 32'h0000_0080);
    access("LH",  32'h0000_1002, 32'd0, 3'd1, 1'b0, 32'h80AA_BBCC,
           32'h0000_1000, 32'd0, 4'h0, 32'hFFFF_80AA);
    access("LHU", 32'h0000_1000, 32'd0, 3'd5, 1'b0, 32'h80AA_BBCC,
           32'h0000_1000, 32'd0, 4'h0, 32'h0000_BBCC);
    access("SH",  32'h0000_1002, 32'h1234_ABCD, 3'd1, 1'b1, 32'hFFFF_FFFF,
           32'h0000_1000, 32'hABCD_ABCD, 4'hC, 32'd0);
    access("SB",  32'h0000_1001, 32'h0000_00A5, 3'd0, 1'b1, 32'hFFFF_FFFF,
           32'h0000_1000, 32'hA5A5_A5A5, 4'h2, 32'd0);

    // LW with three wait cycles
    drive_req(32'h0000_2000, 32'd0, 3'd2, 1'b0);
    mem_rdata = 32'hDEAD_BEEF;
    mem_ready = 1'b0;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wait mem_valid",  {31'd0, mem_valid},  32'd1);
      check("wait mem_addr",   mem_addr, 32'h0000_2000);
      check("wait req_ready",  {31'd0, req_ready},  32'd0);
      check("wait resp_valid", {31'd0, resp_valid}, 32'd0);
      step();
    end
    check("wait4 mem_valid", {31'd0, mem_valid}, 32'd1);
    check("wait4 mem_addr",  mem_addr, 32'h0000_2000);
    check("wait4 req_ready", {31'd0, req_ready}, 32'd0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("wait resp_valid", {31'd0, resp_valid}, 32'd1);
    check("wait resp_rdata", resp_rdata, 32'hDEAD_BEEF);
    step();
    check("wait resp width", {31'd0, resp_valid}, 32'd0);

    // misaligned LW
    drive_req(32'h0000_1001, 32'd0, 3'd2, 1'b0);
    mem_rdata = 32'h1122_3344;
    mem_ready = 1'b1;
    step();
    req_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    check("misal mem_valid",  {31'd0, mem_valid},  32'd0);
    check("misal resp_valid", {31'd0, resp_valid}, 32'd1);
    check("misal resp_err",   {31'd0, resp_err},   32'd1);
    check("misal resp_rdata", resp_rdata, 32'd0);
    step();
`else
    check("misal mem_valid", {31'd0, mem_valid}, 32'd1);
    check("misal mem_addr",  mem_addr, 32'h0000_1000);
    step();
    check("misal resp_valid", {31'd0, resp_valid}, 32'd1);
    check("misal resp_err",   {31'd0, resp_err},   32'd0);
    check("misal resp_rdata", resp_rdata, 32'h1122_3344);
    step();
`endif
    check("misal idle", {31'd0, req_ready}, 32'd1);
    mem_ready = 1'b0;

    // illegal load funct3, then an immediately following LW
    drive_req(32'h0000_0010, 32'd0, 3'd3, 1'b0);
    mem_ready = 1'b1;
    step();
    check("ill mem_valid",  {31'd0, mem_valid},  32'd0);
    check("ill resp_valid", {31'd0, resp_valid}, 32'd1);
    check("ill resp_err",   {31'd0, resp_err},   32'd1);
    check("ill resp_rdata", resp_rdata, 32'd0);
    check("ill req_ready",  {31'd0, req_ready},  32'd0);
    drive_req(32'h0000_0000, 32'd0, 3'd2, 1'b0);
    mem_rdata = 32'hCAFE_F00D;
    step();
    check("next not yet accepted", {31'd0, mem_valid}, 32'd0);
    check("next req_ready",        {31'd0, req_ready}, 32'd1);
    check("next resp gone",        {31'd0, resp_valid}, 32'd0);
    step();
    req_valid = 1'b0;
    check("next mem_valid", {31'd0, mem_valid}, 32'd1);
    check("next mem_addr",  mem_addr, 32'd0);
    step();
    check("next resp_valid", {31'd0, resp_valid}, 32'd1);
    check("next resp_rdata", resp_rdata, 32'hCAFE_F00D);
    check("next resp_err",   {31'd0, resp_err},   32'd0);
    step();
    mem_ready = 1'b0;

    // illegal store funct3
    drive_req(32'h0000_0020, 32'h5555_5555, 3'd4, 1'b1);
    step();
    req_valid = 1'b0;
    check("ill st mem_valid", {31'd0, mem_valid},  32'd0);
    check("ill st resp_err",  {31'd0, resp_err},   32'd1);
    check("ill st resp",      {31'd0, resp_valid}, 32'd1);
    step();

    // reset in the middle of a bus access
    drive_req(32'h0000_4000, 32'd0, 3'd2, 1'b0);
    mem_ready = 1'b0;
    step();
    req_valid = 1'b0;
    check("rstmid mem_valid pre", {31'd0, mem_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid mem_valid async", {31'd0, mem_valid},  32'd0);
    check("rstmid resp_valid",      {31'd0, resp_valid}, 32'd0);
    check("rstmid req_ready",       {31'd0, req_ready},  32'd1);
    step();
    check("rstmid held resp", {31'd0, resp_valid}, 32'd0);
    #2;
    rst = 1'b0;
    step();
    check("rstmid after resp",  {31'd0, resp_valid}, 32'd0);
    check("rstmid after ready", {31'd0, req_ready},  32'd1);
    check("rstmid after mem",   {31'd0, mem_valid},  32'd0);
    access("SW", 32'h0000_3000, 32'h89AB_CDEF, 3'd2, 1'b1, 32'hFFFF_FFFF,
           32'h0000_3000, 32'h89AB_CDEF, 4'hF, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
